// File: rtl/ct_pkg.sv
// Shared definitions for the ct_down_counter slice: default width and an
// all-ones helper sized for any legal counter width.
package ct_pkg;

  localparam int CT_DEFAULT_WIDTH = 4;

  function automatic logic [31:0] ct_all_ones(input int width);
    logic [31:0] ones;
    ones = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) ones[i] = 1'b1;
    end
    return ones;
  endfunction

endpackage

// File: rtl/ct_tff.sv
// Single T flip-flop with asynchronous active-low clear; one per counter bit.
module ct_tff (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= q ^ t;
  end

endmodule

// File: rtl/ct_down_counter.sv
// Free-running synchronous binary down counter built from T flip-flops that
// all share clk; a bit toggles once every bit below it has reached zero.
module ct_down_counter
  import ct_pkg::*;
#(
  parameter int WIDTH = CT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] t;

  // Toggle-enable chain: a borrow propagates upward through bits that are 0.
  assign t[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign t[i] = t[i-1] & ~q[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ct_tff u_tff (
      .clk   (clk),
      .reset (reset),
      .t     (t[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_ct_down_counter.sv
// Scoreboard bench for ct_down_counter at widths 4, 1 and 8 driven by a shared
// clock and reset, with directed phases followed by random reset pulses.
module tb_ct_down_counter;

  logic       clk;
  logic       reset;
  logic [3:0] q4;
  logic [0:0] q1;
  logic [7:0] q8;

  typedef struct {
    logic [31:0] e4;
    logic [31:0] e1;
    logic [31:0] e8;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   fails  = 0;
  int unsigned ref4 = 0;
  int unsigned ref1 = 0;
  int unsigned ref8 = 0;

  ct_down_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .q(q4));
  ct_down_counter #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .q(q1));
  ct_down_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .q(q8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a count value that drops by one modulo 2^W per edge.
  always @(posedge clk or negedge reset) begin
    exp_t e;
    if (!reset) begin
      ref4 = 0;
      ref1 = 0;
      ref8 = 0;
    end else begin
      ref4 = (ref4 + 16 - 1) % 16;
      ref1 = (ref1 + 2 - 1) % 2;
      ref8 = (ref8 + 256 - 1) % 256;
    end
    e.e4 = ref4;
    e.e1 = ref1;
    e.e8 = ref8;
    expq.push_back(e);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic level, input int delay);
    @(negedge clk);
    #(delay);
    reset = level;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or negedge reset);
      #1;
      while (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("q_w4", 32'(q4), e.e4);
        checkOutput("q_w1", 32'(q1), e.e1);
        checkOutput("q_w8", 32'(q8), e.e8);
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(1'b1, 2);
    repeat (6) @(posedge clk);
    applyStimulus(1'b0, 2);
    repeat (3) @(posedge clk);
    applyStimulus(1'b1, 3);
    repeat (300) @(posedge clk);

    for (int i = 0; i < 100; i++) begin
      if (reset && $urandom_range(9) == 0)
        applyStimulus(1'b0, int'($urandom_range(3, 2)));
      else if (!reset && $urandom_range(2) == 0)
        applyStimulus(1'b1, int'($urandom_range(3, 2)));
      else
        @(posedge clk);
    end
    applyStimulus(1'b1, 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #3;

    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
